mult_sequencer: RTL

- Iterative shift-add multiply controller for the FPU integer multiply path (mult/multu).
- Replaces the single-cycle partial-product multiplier with a 32-iteration, one-bit-per-cycle sequence.
- Accepts a start request from the EX-stage controller and stalls the pipeline while running.
- Returns the low 32 product bits plus an overflow flag, and accepts a pipeline-flush abort.

---
 rtl/mult_sequencer_if.sv | 30 +++
 rtl/mult_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: request/response bundle between the EX-stage controller
// and the iterative multiply sequencer.
//   master (controller): drives start, op_unsigned, fbusA, fbusB, abort;
//                        observes busy, stall, done, result, ovf.
//   slave  (sequencer) : the mirror image.
// Operand/result buses use bit 0 = MSB ordering.
interface mult_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             op_unsigned;
  logic [0:WIDTH-1] fbusA;
  logic [0:WIDTH-1] fbusB;
  logic             abort;
  logic             busy;
  logic             stall;
  logic             done;
  logic [0:WIDTH-1] result;
  logic             ovf;

  modport master (
    output start, op_unsigned, fbusA, fbusB, abort,
    input  busy, stall, done, result, ovf
  );

  modport slave (
    input  start, op_unsigned, fbusA, fbusB, abort,
    output busy, stall, done, result, ovf
  );
endinterface

// File: rtl/mult_sequencer.sv
// mult_sequencer: one-bit-per-cycle shift-add multiplier for mult/multu.
// A request is captured in IDLE, iterated for WIDTH cycles on operand
// magnitudes, sign-corrected in one extra cycle, then reported with a
// single-cycle done pulse. The pipeline is stalled while running.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - mult_sequencer_if.slave (start/op_unsigned/fbusA/fbusB/abort in;
//           busy/stall/done/result/ovf out)
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mult_sequencer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    NEG,
    DONE
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               neg;
  logic               opUns;

  logic               busyR;
  logic               doneR;
  logic [WIDTH-1:0]   resultR;
  logic               ovfR;

  logic [WIDTH-1:0]   aVal;
  logic [WIDTH-1:0]   bVal;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [2*WIDTH-1:0] accSigned;
  logic               upperNz;
  logic               ovfNext;

  // Operands arrive MSB-first; plain assignment keeps the numeric value.
  always_comb begin
    aVal = bus.fbusA;
    bVal = bus.fbusB;
    aMag = (!bus.op_unsigned && aVal[WIDTH-1]) ? -aVal : aVal;
    bMag = (!bus.op_unsigned && bVal[WIDTH-1]) ? -bVal : bVal;
  end

  // Overflow is judged on the unsigned magnitude product held in acc.
  always_comb begin
    accSigned = neg ? -acc : acc;
    upperNz   = |acc[2*WIDTH-1:WIDTH];
    if (opUns)
      ovfNext = upperNz;
    else if (!neg)
      ovfNext = upperNz | acc[WIDTH-1];
    else
      ovfNext = upperNz | (acc[WIDTH-1] & (|acc[WIDTH-2:0]));
  end

  assign bus.busy   = busyR;
  assign bus.done   = doneR;
  assign bus.result = resultR;
  assign bus.ovf    = ovfR;
  assign bus.stall  = busyR | (bus.start & (state == IDLE) & ~bus.abort);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      neg     <= 1'b0;
      opUns   <= 1'b0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
      resultR <= '0;
      ovfR    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          doneR <= 1'b0;
          if (bus.start && !bus.abort) begin
            mcand  <= {{WIDTH{1'b0}}, aMag};
            mplier <= bMag;
            neg    <= !bus.op_unsigned && (aVal[WIDTH-1] ^ bVal[WIDTH-1]);
            opUns  <= bus.op_unsigned;
            acc    <= '0;
            count  <= '0;
            busyR  <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          if (bus.abort) begin
            busyR <= 1'b0;
            state <= IDLE;
          end else begin
            // mcand is pre-shifted each step, equivalent to mcand << count.
            if (mplier[0])
              acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (count == CW'(WIDTH - 1))
              state <= NEG;
          end
        end

        NEG: begin
          busyR <= 1'b0;
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            acc     <= accSigned;
            resultR <= accSigned[WIDTH-1:0];
            ovfR    <= ovfNext;
            doneR   <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          doneR <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busyR <= 1'b0;
          doneR <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
